julia_pixel_engine: RTL and testbench

Bitmap-draw producer for the Julia set visualizer: on a start pulse it scans every pixel of the frame, maps it to the complex plane, iterates z ← z² + c in signed fixed point up to a programmable limit, and writes one escape-iteration count per pixel. Its draw/x/y/i output drives the VGA interface's bitmap SDRAM input. Completion of each write is signalled back through a draw acknowledge. Frame parameters come from the Nios-side registers, set by the keycode handler.

---
 rtl/julia_pixel_engine.sv | 218 +++++++++++++++++++++
 tb/tb_julia_pixel_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | julia_pixel_engine: raster-scans a frame, iterates z <- z^2 + c per pixel |
// | and writes one escape-iteration count per pixel.       Revision: 1.0     |
// +--------------------------------------------------------------------------+
module julia_pixel_engine #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int W     = 16,
    parameter int FRAC  = 13
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic signed [W-1:0] c_re_i,
    input  logic signed [W-1:0] c_im_i,
    input  logic signed [W-1:0] re_min_i,
    input  logic signed [W-1:0] im_max_i,
    input  logic signed [W-1:0] step_i,
    input  logic [7:0]          max_iter_i,
    input  logic                draw_ack_i,
    output logic                draw_o,
    output logic [X_W-1:0]      x_o,
    output logic [Y_W-1:0]      y_o,
    output logic [7:0]          i_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int PW = 2 * W;
    localparam logic [X_W-1:0]       X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]       Y_LAST  = Y_W'(V_RES - 1);
    localparam logic signed [PW:0]   ESC_LIM = (PW + 1)'(4 << FRAC);
    localparam logic signed [W-1:0]  S_MAX   = {1'b0, {(W - 1){1'b1}}};
    localparam logic signed [W-1:0]  S_MIN   = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [7:0]           i_q, i_d;
    logic                 draw_q, draw_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic signed [W-1:0]  cur_re_q, cur_re_d;
    logic signed [W-1:0]  cur_im_q, cur_im_d;
    logic signed [W-1:0]  zr_q, zr_d;
    logic signed [W-1:0]  zi_q, zi_d;
    logic [7:0]           k_q, k_d;
    logic signed [W-1:0]  c_re_q, c_re_d;
    logic signed [W-1:0]  c_im_q, c_im_d;
    logic signed [W-1:0]  re_min_q, re_min_d;
    logic signed [W-1:0]  step_q, step_d;
    logic [7:0]           max_iter_q, max_iter_d;

    function automatic logic signed [W-1:0] sat_w(input logic signed [PW+1:0] v);
        if (v > (PW + 2)'(S_MAX)) begin
            return S_MAX;
        end else if (v < (PW + 2)'(S_MIN)) begin
            return S_MIN;
        end else begin
            return $signed(v[W-1:0]);
        end
    endfunction

    // Full-width products keep the magnitude test exact before any clamping.
    logic signed [PW-1:0] w_rr, w_ii, w_ri;
    logic signed [PW-1:0] w_zr2, w_zi2, w_zri;
    logic signed [PW:0]   w_mag;
    logic                 w_escape;
    logic signed [PW+1:0] w_re_nxt, w_im_nxt;

    assign w_rr     = PW'(zr_q) * PW'(zr_q);
    assign w_ii     = PW'(zi_q) * PW'(zi_q);
    assign w_ri     = PW'(zr_q) * PW'(zi_q);
    assign w_zr2    = w_rr >>> FRAC;
    assign w_zi2    = w_ii >>> FRAC;
    assign w_zri    = w_ri >>> (FRAC - 1);
    assign w_mag    = (PW + 1)'(w_zr2) + (PW + 1)'(w_zi2);
    assign w_escape = (w_mag > ESC_LIM);
    assign w_re_nxt = (PW + 2)'(w_zr2) - (PW + 2)'(w_zi2) + (PW + 2)'(c_re_q);
    assign w_im_nxt = (PW + 2)'(w_zri) + (PW + 2)'(c_im_q);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        i_d        = i_q;
        draw_d     = draw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cur_re_d   = cur_re_q;
        cur_im_d   = cur_im_q;
        zr_d       = zr_q;
        zi_d       = zi_q;
        k_d        = k_q;
        c_re_d     = c_re_q;
        c_im_d     = c_im_q;
        re_min_d   = re_min_q;
        step_d     = step_q;
        max_iter_d = max_iter_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    c_re_d     = c_re_i;
                    c_im_d     = c_im_i;
                    re_min_d   = re_min_i;
                    step_d     = step_i;
                    max_iter_d = max_iter_i;
                    x_d        = '0;
                    y_d        = '0;
                    cur_re_d   = re_min_i;
                    cur_im_d   = im_max_i;
                    busy_d     = 1'b1;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                zr_d    = cur_re_q;
                zi_d    = cur_im_q;
                k_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (w_escape || (k_q == max_iter_q)) begin
                    i_d     = k_q;
                    draw_d  = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    zr_d = sat_w(w_re_nxt);
                    zi_d = sat_w(w_im_nxt);
                    k_d  = k_q + 8'd1;
                end
            end
            S_EMIT: begin
                if (draw_ack_i) begin
                    draw_d = 1'b0;
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_INIT;
                        // Plane coordinates advance by accumulation, wrapping mod 2^W.
                        if (x_q != X_LAST) begin
                            x_d      = x_q + 1'b1;
                            cur_re_d = cur_re_q + step_q;
                        end else begin
                            x_d      = '0;
                            cur_re_d = re_min_q;
                            y_d      = y_q + 1'b1;
                            cur_im_d = cur_im_q - step_q;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            i_q        <= '0;
            draw_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cur_re_q   <= '0;
            cur_im_q   <= '0;
            zr_q       <= '0;
            zi_q       <= '0;
            k_q        <= '0;
            c_re_q     <= '0;
            c_im_q     <= '0;
            re_min_q   <= '0;
            step_q     <= '0;
            max_iter_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            i_q        <= i_d;
            draw_q     <= draw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cur_re_q   <= cur_re_d;
            cur_im_q   <= cur_im_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            k_q        <= k_d;
            c_re_q     <= c_re_d;
            c_im_q     <= c_im_d;
            re_min_q   <= re_min_d;
            step_q     <= step_d;
            max_iter_q <= max_iter_d;
        end
    end

    assign draw_o = draw_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign i_o    = i_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_julia_pixel_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_julia_pixel_engine: directed checks on a 2x2 and a 640x480 instance.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_julia_pixel_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // 2x2 frame instance
    logic        s_rst, s_start, s_ack;
    logic [15:0] s_cre, s_cim, s_remin, s_immax, s_step;
    logic [7:0]  s_maxit;
    logic        s_draw, s_busy, s_done;
    logic [9:0]  s_x;
    logic [8:0]  s_y;
    logic [7:0]  s_i;

    // full 640x480 instance
    logic        l_rst, l_start, l_ack;
    logic [15:0] l_cre, l_cim, l_remin, l_immax, l_step;
    logic [7:0]  l_maxit;
    logic        l_draw, l_busy, l_done;
    logic [9:0]  l_x;
    logic [8:0]  l_y;
    logic [7:0]  l_i;

    int s_done_cnt = 0;
    int l_done_cnt = 0;
    always @(posedge clk) begin
        if (s_done) s_done_cnt <= s_done_cnt + 1;
        if (l_done) l_done_cnt <= l_done_cnt + 1;
    end

    julia_pixel_engine #(.H_RES(2), .V_RES(2)) u_small (
        .clk_i(clk), .reset_i(s_rst), .start_i(s_start),
        .c_re_i(s_cre), .c_im_i(s_cim), .re_min_i(s_remin), .im_max_i(s_immax),
        .step_i(s_step), .max_iter_i(s_maxit), .draw_ack_i(s_ack),
        .draw_o(s_draw), .x_o(s_x), .y_o(s_y), .i_o(s_i),
        .busy_o(s_busy), .done_o(s_done)
    );

    julia_pixel_engine u_large (
        .clk_i(clk), .reset_i(l_rst), .start_i(l_start),
        .c_re_i(l_cre), .c_im_i(l_cim), .re_min_i(l_remin), .im_max_i(l_immax),
        .step_i(l_step), .max_iter_i(l_maxit), .draw_ack_i(l_ack),
        .draw_o(l_draw), .x_o(l_x), .y_o(l_y), .i_o(l_i),
        .busy_o(l_busy), .done_o(l_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_draw(input bit big, input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if ((big ? l_draw : s_draw) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("draw_within_bound", 32'(ok), 32'd1);
    endtask

    // Ack tied high; every pixel of the 2x2 frame is expected to give exp_i.
    task automatic run_small(input logic [15:0] remin, input logic [7:0] mi, input int exp_i);
        int t_prev, dc0;
        @(negedge clk);
        s_cre = '0; s_cim = '0; s_remin = remin; s_immax = '0; s_step = '0;
        s_maxit = mi; s_ack = 1'b1; s_start = 1'b1;
        dc0 = s_done_cnt;
        @(negedge clk);
        s_start = 1'b0;
        check_val($sformatf("busy_after_start_r%0d", remin), 32'(s_busy), 32'd1);
        t_prev = cyc;
        for (int p = 0; p < 4; p++) begin
            wait_draw(1'b0, 400);
            check_val($sformatf("gap_r%0d_m%0d_p%0d", remin, mi, p), 32'(cyc - t_prev),
                      32'((p == 0) ? exp_i + 2 : exp_i + 3));
            check_val($sformatf("x_r%0d_p%0d", remin, p), 32'(s_x), 32'(p % 2));
            check_val($sformatf("y_r%0d_p%0d", remin, p), 32'(s_y), 32'(p / 2));
            check_val($sformatf("i_r%0d_m%0d_p%0d", remin, mi, p), 32'(s_i), 32'(exp_i));
            t_prev = cyc;
        end
        @(negedge clk);
        check_val("done_pulse", 32'(s_done), 32'd1);
        check_val("busy_fall", 32'(s_busy), 32'd0);
        @(negedge clk);
        check_val("done_one_cycle", 32'(s_done), 32'd0);
        check_val("done_count", 32'(s_done_cnt - dc0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev, ex, ey, ei, dc0;
        s_rst = 1'b1; s_start = 1'b0; s_ack = 1'b0;
        s_cre = '0; s_cim = '0; s_remin = '0; s_immax = '0; s_step = '0; s_maxit = '0;
        l_rst = 1'b1; l_start = 1'b0; l_ack = 1'b0;
        l_cre = '0; l_cim = '0; l_remin = '0; l_immax = '0; l_step = '0; l_maxit = '0;
        repeat (3) @(negedge clk);
        check_val("reset_small_outputs", {s_draw, s_x, s_y, s_i, s_busy, s_done}, 32'd0);
        check_val("reset_large_outputs", {l_draw, l_x, l_y, l_i, l_busy, l_done}, 32'd0);
        s_rst = 1'b0;
        l_rst = 1'b0;

        // bounded origin, immediate escape at 3.0, one-iteration escape at 1.5, max_iter=0
        run_small(16'd0,     8'd20, 20);
        run_small(16'd24576, 8'd20, 0);
        run_small(16'd12288, 8'd20, 1);
        run_small(16'd0,     8'd0,  0);

        // backpressure: the pixel must hold while ack stays low
        @(negedge clk);
        s_remin = '0; s_maxit = 8'd5; s_ack = 1'b0; s_start = 1'b1;
        dc0 = s_done_cnt;
        @(negedge clk);
        s_start = 1'b0;
        wait_draw(1'b0, 100);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_val($sformatf("bp_hold_%0d", n), {s_draw, s_x, s_y, s_i},
                      {1'b1, 10'd0, 9'd0, 8'd5});
        end
        for (int p = 1; p < 4; p++) begin
            s_ack = 1'b1;
            @(negedge clk);
            s_ack = 1'b0;
            check_val($sformatf("bp_draw_drop_%0d", p), 32'(s_draw), 32'd0);
            wait_draw(1'b0, 100);
            check_val($sformatf("bp_xy_%0d", p), {s_x, s_y}, {10'(p % 2), 9'(p / 2)});
            @(negedge clk);
            check_val($sformatf("bp_still_%0d", p), {s_draw, s_x, s_y, s_i},
                      {1'b1, 10'(p % 2), 9'(p / 2), 8'd5});
        end
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        check_val("bp_done", 32'(s_done), 32'd1);
        @(negedge clk);
        check_val("bp_done_count", 32'(s_done_cnt - dc0), 32'd1);

        // full-width frame: columns up to 320 need one iteration, beyond escape at once
        @(negedge clk);
        l_cre = '0; l_cim = '0; l_remin = 16'd16064; l_immax = '0; l_step = 16'd1;
        l_maxit = 8'd20; l_ack = 1'b1; l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        t_prev = cyc;
        for (int p = 0; p <= 640; p++) begin
            ex = p % 640;
            ey = p / 640;
            ei = (ey == 0 && ex > 320) ? 0 : 1;
            wait_draw(1'b1, 100);
            check_val($sformatf("L_gap_p%0d", p), 32'(cyc - t_prev),
                      32'((p == 0) ? ei + 2 : ei + 3));
            check_val($sformatf("L_x_p%0d", p), 32'(l_x), 32'(ex));
            check_val($sformatf("L_y_p%0d", p), 32'(l_y), 32'(ey));
            check_val($sformatf("L_i_p%0d", p), 32'(l_i), 32'(ei));
            t_prev = cyc;
            if (p == 100) begin
                l_start = 1'b1; l_remin = '0; l_step = 16'd100; l_maxit = '0;
                l_cre = 16'h7000; l_immax = 16'h1000;
                @(negedge clk);
                l_start = 1'b0;
                check_val("L_busy_during_restart", 32'(l_busy), 32'd1);
            end
            if (p == 640) l_ack = 1'b0;
        end
        check_val("L_no_done_midframe", 32'(l_done_cnt), 32'd0);

        // reset while pixel (0,1) is waiting for its ack
        @(negedge clk);
        check_val("L_pending_draw", {l_draw, l_x, l_y}, {1'b1, 10'd0, 9'd1});
        l_rst = 1'b1;
        @(negedge clk);
        l_rst = 1'b0;
        check_val("L_reset_outputs", {l_draw, l_busy, l_x, l_y, l_i, l_done}, 32'd0);
        l_ack = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            check_val($sformatf("L_idle_after_reset_%0d", n), {l_draw, l_busy}, 32'd0);
        end
        check_val("L_no_done_after_reset", 32'(l_done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
